// File: rtl/hdr_ddr_ctrl.sv
// HDR-DDR transfer sequencer: command fetch/send, data frames to/from the regfile, optional CRC5 word.
// Define HDR_DDR_CRC_EN to include the trailing CRC frame; without it the last data frame ends the transfer.
module hdr_ddr_ctrl #(
  parameter logic [11:0] REGF_BASE = 12'd1000,
  parameter int          FRM_W     = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_ddrmode_en,
  input  logic [15:0]      i_regf_rd_data,
  input  logic             i_regf_rnw,
  input  logic [FRM_W-1:0] i_regf_dtcnt,
  input  logic             i_tx_mode_done,
  input  logic             i_rx_mode_done,
  input  logic [15:0]      i_rx_data,
  input  logic [1:0]       i_rx_par,
  output logic             o_regf_rd_en,
  output logic             o_regf_wr_en,
  output logic [11:0]      o_regf_addr,
  output logic [15:0]      o_regf_wr_data,
  output logic             o_tx_en,
  output logic [2:0]       o_tx_mode,
  output logic [15:0]      o_tx_word,
  output logic [1:0]       o_tx_par,
  output logic             o_rx_en,
  output logic [FRM_W-1:0] o_frm_cnt,
  output logic             o_ddr_mode_done,
  output logic             o_par_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH_CMD, ST_CMD_TX, ST_FETCH_DATA, ST_DATA_TX, ST_DATA_RX, ST_DONE
`ifdef HDR_DDR_CRC_EN
    , ST_CRC
`endif
  } state_t;

  state_t           state_reg;
  logic             en_d_reg;
  logic             rnw_reg;
  logic [FRM_W-1:0] dtcnt_reg;
  logic             fetch_wait_reg;
`ifdef HDR_DDR_CRC_EN
  logic [4:0]       crc_reg;
`endif

  logic [FRM_W-1:0] frm_inc;
  logic             last_frm;
  logic [11:0]      data_addr;
  logic [11:0]      data_addr_inc;

  assign frm_inc       = o_frm_cnt + {{(FRM_W-1){1'b0}}, 1'b1};
  assign last_frm      = (frm_inc == dtcnt_reg);
  assign data_addr     = REGF_BASE + 12'd1 + 12'(o_frm_cnt);
  assign data_addr_inc = REGF_BASE + 12'd1 + 12'(frm_inc);

  // par[1] covers the odd bits, par[0] is the inverted XOR of the even bits
  function automatic logic [1:0] par_of(input logic [15:0] w);
    logic odd_x, even_x;
    odd_x  = 1'b0;
    even_x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      odd_x  = odd_x ^ w[2*i+1];
      even_x = even_x ^ w[2*i];
    end
    return {odd_x, ~even_x};
  endfunction

`ifdef HDR_DDR_CRC_EN
  // CRC5 x^5+x^2+1, one bit per step, MSB first
  function automatic logic [4:0] crc_of(input logic [4:0] c, input logic [15:0] w);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[4] ^ w[i];
      r  = {r[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
    end
    return r;
  endfunction
`endif

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_reg       <= ST_IDLE;
      // Treat the enable as already high so a level held through reset cannot start a transfer
      en_d_reg        <= 1'b1;
      rnw_reg         <= 1'b0;
      dtcnt_reg       <= '0;
      fetch_wait_reg  <= 1'b0;
`ifdef HDR_DDR_CRC_EN
      crc_reg         <= 5'h1F;
`endif
      o_regf_rd_en    <= 1'b0;
      o_regf_wr_en    <= 1'b0;
      o_regf_addr     <= '0;
      o_regf_wr_data  <= '0;
      o_tx_en         <= 1'b0;
      o_tx_mode       <= '0;
      o_tx_word       <= '0;
      o_tx_par        <= '0;
      o_rx_en         <= 1'b0;
      o_frm_cnt       <= '0;
      o_ddr_mode_done <= 1'b0;
      o_par_err       <= 1'b0;
    end else begin
      en_d_reg        <= i_ddrmode_en;
      o_regf_rd_en    <= 1'b0;
      o_regf_wr_en    <= 1'b0;
      o_ddr_mode_done <= 1'b0;
      if (state_reg != ST_IDLE && !i_ddrmode_en) begin
        // Abort wins over any completion arriving in the same cycle
        state_reg      <= ST_IDLE;
        o_tx_en        <= 1'b0;
        o_tx_mode      <= '0;
        o_rx_en        <= 1'b0;
        fetch_wait_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (i_ddrmode_en && !en_d_reg) begin
              rnw_reg        <= i_regf_rnw;
              dtcnt_reg      <= i_regf_dtcnt;
              o_par_err      <= 1'b0;
              o_frm_cnt      <= '0;
`ifdef HDR_DDR_CRC_EN
              crc_reg        <= 5'h1F;
`endif
              o_regf_rd_en   <= 1'b1;
              o_regf_addr    <= REGF_BASE;
              fetch_wait_reg <= 1'b0;
              state_reg      <= ST_FETCH_CMD;
            end
          end
          ST_FETCH_CMD: begin
            if (!fetch_wait_reg) begin
              fetch_wait_reg <= 1'b1;
            end else begin
              fetch_wait_reg <= 1'b0;
              o_tx_word      <= i_regf_rd_data;
              o_tx_par       <= par_of(i_regf_rd_data);
              o_tx_en        <= 1'b1;
              o_tx_mode      <= 3'd1;
              state_reg      <= ST_CMD_TX;
            end
          end
          ST_CMD_TX: begin
            if (i_tx_mode_done) begin
              o_tx_en   <= 1'b0;
              o_tx_mode <= '0;
              if (dtcnt_reg == '0) begin
                o_ddr_mode_done <= 1'b1;
                state_reg       <= ST_DONE;
              end else if (rnw_reg) begin
                o_rx_en   <= 1'b1;
                state_reg <= ST_DATA_RX;
              end else begin
                o_regf_rd_en <= 1'b1;
                o_regf_addr  <= data_addr;
                state_reg    <= ST_FETCH_DATA;
              end
            end
          end
          ST_FETCH_DATA: begin
            if (!fetch_wait_reg) begin
              fetch_wait_reg <= 1'b1;
            end else begin
              fetch_wait_reg <= 1'b0;
              o_tx_word      <= i_regf_rd_data;
              o_tx_par       <= par_of(i_regf_rd_data);
              o_tx_en        <= 1'b1;
              o_tx_mode      <= 3'd2;
`ifdef HDR_DDR_CRC_EN
              crc_reg        <= crc_of(crc_reg, i_regf_rd_data);
`endif
              state_reg      <= ST_DATA_TX;
            end
          end
          ST_DATA_TX: begin
            if (i_tx_mode_done) begin
              o_tx_en   <= 1'b0;
              o_tx_mode <= '0;
              o_frm_cnt <= frm_inc;
              if (last_frm) begin
`ifdef HDR_DDR_CRC_EN
                o_tx_en   <= 1'b1;
                o_tx_mode <= 3'd3;
                o_tx_word <= {11'd0, crc_reg};
                o_tx_par  <= par_of({11'd0, crc_reg});
                state_reg <= ST_CRC;
`else
                o_ddr_mode_done <= 1'b1;
                state_reg       <= ST_DONE;
`endif
              end else begin
                o_regf_rd_en <= 1'b1;
                o_regf_addr  <= data_addr_inc;
                state_reg    <= ST_FETCH_DATA;
              end
            end
          end
          ST_DATA_RX: begin
            if (i_rx_mode_done) begin
              if (par_of(i_rx_data) != i_rx_par) begin
                o_par_err       <= 1'b1;
                o_rx_en         <= 1'b0;
                o_ddr_mode_done <= 1'b1;
                state_reg       <= ST_DONE;
              end else begin
                o_regf_wr_en   <= 1'b1;
                o_regf_addr    <= data_addr;
                o_regf_wr_data <= i_rx_data;
                o_frm_cnt      <= frm_inc;
`ifdef HDR_DDR_CRC_EN
                crc_reg        <= crc_of(crc_reg, i_rx_data);
                // rx stays requested: the CRC word is the next frame
                if (last_frm) state_reg <= ST_CRC;
`else
                if (last_frm) begin
                  o_rx_en         <= 1'b0;
                  o_ddr_mode_done <= 1'b1;
                  state_reg       <= ST_DONE;
                end
`endif
              end
            end
          end
`ifdef HDR_DDR_CRC_EN
          ST_CRC: begin
            if (rnw_reg) begin
              if (i_rx_mode_done) begin
                if (i_rx_data[4:0] != crc_reg) o_par_err <= 1'b1;
                o_rx_en         <= 1'b0;
                o_ddr_mode_done <= 1'b1;
                state_reg       <= ST_DONE;
              end
            end else if (i_tx_mode_done) begin
              o_tx_en         <= 1'b0;
              o_tx_mode       <= '0;
              o_ddr_mode_done <= 1'b1;
              state_reg       <= ST_DONE;
            end
          end
`endif
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
